// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared widths, the R0 address and the write-back source select encoding
package wb_regfile_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int REG_ZERO = 0;
  typedef enum logic {
    WB_SEL_ALU = 1'b0,
    WB_SEL_MEM = 1'b1
  } wb_sel_e;
endpackage

// File: rtl/wb_regfile_rf_read_port.sv
// rf_read_port: one combinational register-file read port.
// R0 reads as zero, a committing write to the same register is bypassed, otherwise the array is read.
module rf_read_port
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0]                    rd_addr_i,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]     regs_i,
  input  logic                                 wb_valid_i,
  input  logic [ADDR_W-1:0]                    wb_addr_i,
  input  logic [DATA_W-1:0]                    wb_data_i,
  output logic [DATA_W-1:0]                    rd_data_o
);
  always_comb begin
    rd_data_o = (rd_addr_i == ADDR_W'(REG_ZERO)) ? '0 :
                (wb_valid_i && rd_addr_i == wb_addr_i) ? wb_data_i : regs_i[rd_addr_i];
  end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage, 2**ADDR_W-entry register file with bypassing read ports and sticky halt.
// Optional retire counter output retire_cnt when WB_RETIRE_CNT_EN is defined.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
`ifdef WB_RETIRE_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ldata_wb,
  input  logic [DATA_W-1:0] alu_result_wb,
  input  logic              wb_sel_wb,
  input  logic              we_rf_wb,
  input  logic [ADDR_W-1:0] dst_addr_wb,
  input  logic              hlt_wb,
  input  logic              stall,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data0,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_valid,
  output logic              halted
`ifdef WB_RETIRE_CNT_EN
  , output logic [CNT_W-1:0] retire_cnt
`endif
);
  logic [2**ADDR_W-1:0][DATA_W-1:0] regs_q;
  logic halted_q, halted_d;
  always_comb begin
    wb_data  = (wb_sel_e'(wb_sel_wb) == WB_SEL_MEM) ? ldata_wb : alu_result_wb;
    wb_valid = we_rf_wb & ~stall & ~halted_q & (dst_addr_wb != ADDR_W'(REG_ZERO));
    halted_d = halted_q | (hlt_wb & ~stall);
  end
  // regs_q[0] is never written, so it stays zero from reset onward
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
      if (wb_valid) regs_q[dst_addr_wb] <= wb_data;
    end
  end
  assign halted = halted_q;
  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd0 (
    .rd_addr_i (rd_addr0),
    .regs_i    (regs_q),
    .wb_valid_i(wb_valid),
    .wb_addr_i (dst_addr_wb),
    .wb_data_i (wb_data),
    .rd_data_o (rd_data0)
  );
  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .rd_addr_i (rd_addr1),
    .regs_i    (regs_q),
    .wb_valid_i(wb_valid),
    .wb_addr_i (dst_addr_wb),
    .wb_data_i (wb_data),
    .rd_data_o (rd_data1)
  );
`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // HLT occupies the slot too, so it retires like any other instruction
  always_comb begin
    cnt_d = (~stall & ~halted_q & (we_rf_wb | hlt_wb) & ~(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign retire_cnt = cnt_q;
`endif
endmodule
